// File: rtl/uart_cmd_controller.sv
// Command sequencer: parses SYNC/CMD/ADDR/DATA/CHK frames from the UART receiver,
// executes register reads/writes and returns a status + data byte through the transmitter.
module uart_cmd_controller #(
  parameter int unsigned NUM_REGS     = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  cmd_done,
  output logic [7:0]            err_count
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [3:0] {
    IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC,
    SEND_ST, WAIT_ST, SEND_DT, WAIT_DT, DONE
  } state_t;

  state_t r_state, w_next;

  logic [7:0]            r_cmd, r_addr, r_data, r_chk, r_resp;
  logic [7:0]            r_tx_data, r_err_count;
  logic [TW-1:0]         r_tout;
  logic                  r_wait_first;
  logic [8*NUM_REGS-1:0] r_regs;

  logic                  w_in_get, w_timeout;
  logic                  w_chk_bad, w_cmd_bad, w_addr_bad, w_is_write, w_err;
  logic [7:0]            w_status, w_resp;
  logic [AW-1:0]         w_idx;

  assign w_in_get   = (r_state == GET_CMD) || (r_state == GET_ADDR) ||
                      (r_state == GET_DATA) || (r_state == GET_CHK);
  assign w_timeout  = w_in_get && !rx_valid && (r_tout == TW'(TIMEOUT_CLKS));
  assign w_idx      = r_addr[AW-1:0];
  assign w_is_write = (r_cmd == 8'h01);
  assign w_chk_bad  = (r_chk != (r_cmd ^ r_addr ^ r_data));
  assign w_cmd_bad  = (r_cmd != 8'h01) && (r_cmd != 8'h02);
  assign w_addr_bad = (32'(r_addr) >= NUM_REGS);
  assign w_err      = w_chk_bad || w_cmd_bad || w_addr_bad;

  always_comb begin
    w_status = 8'h00;
    if (w_chk_bad)       w_status = 8'hE1;
    else if (w_cmd_bad)  w_status = 8'hE2;
    else if (w_addr_bad) w_status = 8'hE3;
  end

  always_comb begin
    w_resp = 8'h00;
    if (!w_err) w_resp = w_is_write ? r_data : r_regs[{w_idx, 3'b000} +: 8];
  end

  always_comb begin
    w_next   = r_state;
    tx_start = 1'b0;
    cmd_done = 1'b0;
    case (r_state)
      IDLE:     if (rx_valid && rx_data == SYNC_BYTE) w_next = GET_CMD;
      GET_CMD:  if (rx_valid) w_next = GET_ADDR; else if (w_timeout) w_next = IDLE;
      GET_ADDR: if (rx_valid) w_next = GET_DATA; else if (w_timeout) w_next = IDLE;
      GET_DATA: if (rx_valid) w_next = GET_CHK;  else if (w_timeout) w_next = IDLE;
      GET_CHK:  if (rx_valid) w_next = EXEC;     else if (w_timeout) w_next = IDLE;
      EXEC:     w_next = SEND_ST;
      SEND_ST: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          w_next   = WAIT_ST;
        end
      end
      // first WAIT cycle may still see the pre-start low of tx_busy
      WAIT_ST:  if (!r_wait_first && !tx_busy) w_next = SEND_DT;
      SEND_DT: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          w_next   = WAIT_DT;
        end
      end
      WAIT_DT:  if (!r_wait_first && !tx_busy) w_next = DONE;
      DONE: begin
        cmd_done = 1'b1;
        w_next   = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_chk        <= '0;
      r_resp       <= '0;
      r_tx_data    <= '0;
      r_err_count  <= '0;
      r_tout       <= '0;
      r_wait_first <= 1'b0;
      r_regs       <= '0;
    end else begin
      r_wait_first <= tx_start;

      if (!w_in_get || rx_valid)            r_tout <= '0;
      else if (r_tout != TW'(TIMEOUT_CLKS)) r_tout <= r_tout + 1'b1;

      if (rx_valid) begin
        case (r_state)
          GET_CMD:  r_cmd  <= rx_data;
          GET_ADDR: r_addr <= rx_data;
          GET_DATA: r_data <= rx_data;
          GET_CHK:  r_chk  <= rx_data;
          default:  ;
        endcase
      end

      if (w_timeout && r_err_count != '1) r_err_count <= r_err_count + 8'd1;

      if (r_state == EXEC) begin
        r_tx_data <= w_status;
        r_resp    <= w_resp;
        if (!w_err && w_is_write) r_regs[{w_idx, 3'b000} +: 8] <= r_data;
        if (w_err && r_err_count != '1) r_err_count <= r_err_count + 8'd1;
      end

      // data byte is presented only once the status byte has fully left
      if (r_state == WAIT_ST && w_next == SEND_DT) r_tx_data <= r_resp;
    end
  end

  assign tx_data   = r_tx_data;
  assign regs_flat = r_regs;
  assign err_count = r_err_count;

endmodule
